// File: rtl/fp_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_pkg
//  Description : Shared types and helpers for the add/sub operand issue queue.
//                IEEE 754 single-precision field widths, the per-operand
//                class flags {nan, inf, denorm, zero}, the stored queue
//                entry, and exponent/mantissa field extractors.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_addsub_pkg;

    localparam int unsigned c_EXP_BITS  = 8;
    localparam int unsigned c_MANT_BITS = 23;
    localparam int unsigned c_WIDTH     = 1 + c_EXP_BITS + c_MANT_BITS;

    // Class flags. Bit order matters: the packed value is exported as
    // {nan, inf, denorm, zero} on the queue outputs.
    typedef struct packed {
        logic nan;
        logic inf;
        logic denorm;
        logic zero;
    } fp_class_t;

    // One queued request plus the flags computed when it was enqueued.
    typedef struct packed {
        logic [c_WIDTH-1:0] a;
        logic [c_WIDTH-1:0] b;
        logic               op;
        fp_class_t          cls_a;
        fp_class_t          cls_b;
    } issue_entry_t;

    // Both extractors take the magnitude (sign bit already stripped), since
    // classification never looks at the sign.
    function automatic logic [c_EXP_BITS-1:0] fp_exp(input logic [c_WIDTH-2:0] mag);
        return mag[c_WIDTH-2 -: c_EXP_BITS];
    endfunction

    function automatic logic [c_MANT_BITS-1:0] fp_mant(input logic [c_WIDTH-2:0] mag);
        return mag[c_MANT_BITS-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational IEEE 754 operand classifier. Takes the
//                magnitude bits of an operand (sign excluded, so -0 is zero)
//                and produces {nan, inf, denorm, zero}; a normal number
//                yields 4'b0000.
//  Ports       : i_mag   in  EXP_BITS+MANT_BITS  exponent and mantissa fields
//                o_class out fp_class_t          class flags
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_classify
    import fp_addsub_pkg::*;
#(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input  logic [EXP_BITS+MANT_BITS-1:0] i_mag,
    output fp_class_t                     o_class
);

    logic [EXP_BITS-1:0]  w_exp;
    logic [MANT_BITS-1:0] w_mant;
    logic                 w_exp_ones;
    logic                 w_exp_zero;
    logic                 w_mant_nz;

    // Use the shared extractors for the standard format; other formats slice
    // the fields directly from their own parameters.
    generate
        if (EXP_BITS == c_EXP_BITS && MANT_BITS == c_MANT_BITS) begin : g_pkg_fields
            assign w_exp  = fp_exp(i_mag);
            assign w_mant = fp_mant(i_mag);
        end else begin : g_generic_fields
            assign w_exp  = i_mag[EXP_BITS+MANT_BITS-1 -: EXP_BITS];
            assign w_mant = i_mag[MANT_BITS-1:0];
        end
    endgenerate

    assign w_exp_ones = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_mant_nz  = |w_mant;

    always_comb begin
        o_class        = '0;
        o_class.nan    = w_exp_ones &  w_mant_nz;
        o_class.inf    = w_exp_ones & ~w_mant_nz;
        o_class.denorm = w_exp_zero &  w_mant_nz;
        o_class.zero   = w_exp_zero & ~w_mant_nz;
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_issue_queue
//  Description : Operand issue FIFO in front of add_sub_main. Buffers
//                {a, b, op} requests on a valid/ready handshake, classifies
//                each operand on enqueue and presents the head entry with
//                its class flags. Outputs read zero while the queue is empty.
//  Ports       : clk, reset (async, active-high), flush (sync clear)
//                in_valid/in_ready/in_a/in_b/in_op      request side
//                out_valid/out_ready/out_a/out_b/out_op  issue side
//                out_class_a/out_class_b                 {nan,inf,denorm,zero}
//                count                                   occupancy
//                stat_issued/stat_full_stall             only with
//                                                        FP_ISSUE_STATS_EN
//  Options     : FP_ISSUE_STATS_EN - adds saturating pop and full-stall
//                counters, cleared by reset only.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_issue_queue
    import fp_addsub_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_a,
    output logic [WIDTH-1:0]       out_b,
    output logic                   out_op,
    output logic [3:0]             out_class_a,
    output logic [3:0]             out_class_b,
    output logic [$clog2(DEPTH):0] count
`ifdef FP_ISSUE_STATS_EN
    ,
    output logic [31:0]            stat_issued,
    output logic [15:0]            stat_full_stall
`endif
);

    localparam int                c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL    = DEPTH[c_PTR_W:0];
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_PTR_W:0]  c_CNT_ONE = 1;

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    generate
        if (WIDTH != 1 + EXP_BITS + MANT_BITS) begin : g_chk_fields
            $error("fp_addsub_issue_queue: WIDTH must equal 1+EXP_BITS+MANT_BITS");
        end
        // The stored entry type is fixed to the package's operand format.
        if (WIDTH != c_WIDTH) begin : g_chk_entry
            $error("fp_addsub_issue_queue: WIDTH must match the package operand width");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
            $error("fp_addsub_issue_queue: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Enqueue-side classification
    // ------------------------------------------------------------------
    fp_class_t    w_cls_a;
    fp_class_t    w_cls_b;
    issue_entry_t w_in_entry;

    fp_classify #(
        .EXP_BITS  (EXP_BITS),
        .MANT_BITS (MANT_BITS)
    ) u_classify_a (
        .i_mag   (in_a[WIDTH-2:0]),
        .o_class (w_cls_a)
    );

    fp_classify #(
        .EXP_BITS  (EXP_BITS),
        .MANT_BITS (MANT_BITS)
    ) u_classify_b (
        .i_mag   (in_b[WIDTH-2:0]),
        .o_class (w_cls_b)
    );

    always_comb begin
        w_in_entry       = '0;
        w_in_entry.a     = in_a;
        w_in_entry.b     = in_b;
        w_in_entry.op    = in_op;
        w_in_entry.cls_a = w_cls_a;
        w_in_entry.cls_b = w_cls_b;
    end

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    // Full/empty come from the occupancy counter only, so in_ready is a
    // pure register decode and never sees out_ready.
    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    // flush discards whatever handshakes happen in its cycle.
    assign w_push = in_valid & ~w_full & ~flush;
    assign w_pop  = out_ready & ~w_empty & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage (not reset; validity is tracked by r_count)
    // ------------------------------------------------------------------
    issue_entry_t r_mem [DEPTH];
    issue_entry_t w_head;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Outputs: head fields are masked to zero while empty so downstream
    // never sees stale entries, including right after an async reset.
    // ------------------------------------------------------------------
    assign in_ready    = ~w_full;
    assign out_valid   = ~w_empty;
    assign out_a       = w_empty ? '0   : w_head.a;
    assign out_b       = w_empty ? '0   : w_head.b;
    assign out_op      = w_empty ? 1'b0 : w_head.op;
    assign out_class_a = w_empty ? 4'b0 : w_head.cls_a;
    assign out_class_b = w_empty ? 4'b0 : w_head.cls_b;
    assign count       = r_count;

`ifdef FP_ISSUE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics, deliberately untouched by flush.
    // ------------------------------------------------------------------
    logic [31:0] r_stat_issued;
    logic [15:0] r_stat_full_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_issued     <= '0;
            r_stat_full_stall <= '0;
        end else begin
            if (w_pop && (r_stat_issued != '1)) begin
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            if (in_valid && w_full && (r_stat_full_stall != '1)) begin
                r_stat_full_stall <= r_stat_full_stall + 16'd1;
            end
        end
    end

    assign stat_issued     = r_stat_issued;
    assign stat_full_stall = r_stat_full_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_addsub_issue_queue
//  Description : Scoreboard bench for fp_addsub_issue_queue. Each accepted
//                request pushes its hand-classified expected entry into a
//                queue; an independent monitor pops and compares on every
//                DUT pop. Directed state checks cover reset, full, flush
//                and same-cycle push/pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_issue_queue;
    import fp_addsub_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_op;
    logic [3:0]  out_class_a;
    logic [3:0]  out_class_b;
    logic [2:0]  count;
`ifdef FP_ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [15:0] stat_full_stall;
`endif

    always #5 clk = ~clk;

    fp_addsub_issue_queue #(
        .WIDTH     (32),
        .EXP_BITS  (8),
        .MANT_BITS (23),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_op      (out_op),
        .out_class_a (out_class_a),
        .out_class_b (out_class_b),
        .count       (count)
`ifdef FP_ISSUE_STATS_EN
        ,
        .stat_issued     (stat_issued),
        .stat_full_stall (stat_full_stall)
`endif
    );

    int           n_pass    = 0;
    int           n_total   = 0;
    int           model_cnt = 0;
    issue_entry_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever the head is
    // valid, out_ready is high and no flush is pending.
    always @(negedge clk) begin
        issue_entry_t e;
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: actual=%h required=none", out_a);
            end else begin
                e = exp_q.pop_front();
                chk("pop_a",     out_a, e.a);
                chk("pop_b",     out_b, e.b);
                chk("pop_op",    {31'b0, out_op}, {31'b0, e.op});
                chk("pop_cls_a", {28'b0, out_class_a}, {28'b0, e.cls_a});
                chk("pop_cls_b", {28'b0, out_class_b}, {28'b0, e.cls_b});
            end
        end
    end

    // One clock of stimulus. Inputs are applied just after a rising edge and
    // returned to idle just after the next one.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [3:0] ca, input logic [3:0] cb,
                        input logic rdy, input logic fl);
        issue_entry_t e;
        bit acc;
        bit pop;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        if (v) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (model_cnt < DEPTH)});
        end
        acc = v && (model_cnt < DEPTH) && !fl;
        pop = rdy && (model_cnt > 0) && !fl;
        if (fl) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (acc) begin
                e.a     = a;
                e.b     = b;
                e.op    = op;
                e.cls_a = ca;
                e.cls_b = cb;
                exp_q.push_back(e);
            end
            model_cnt = model_cnt + int'(acc) - int'(pop);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [3:0] ca, input logic [3:0] cb);
        step(1'b1, a, b, op, ca, cb, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (model_cnt > 0) pop1();
        end
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_count"},     {29'b0, count},     32'd0);
        chk({tag, "_out_a"},     out_a,              32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset with a request presented: nothing may be accepted.
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'hDEADBEEF;
        in_b      = 32'h12345678;
        in_op     = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_count",     {29'b0, count},     32'd0);
        chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset_out_a",     out_a,              32'd0);
        chk("reset_class_a",   {28'b0, out_class_a}, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;

        // Single push: head visible the cycle after the accepting edge.
        push(32'h40400000, 32'h40800000, 1'b0, 4'b0000, 4'b0000);
        chk("t2_out_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_out_a",     out_a, 32'h40400000);
        chk("t2_out_b",     out_b, 32'h40800000);
        chk("t2_out_op",    {31'b0, out_op}, 32'd0);
        chk("t2_class_a",   {28'b0, out_class_a}, 32'd0);
        chk("t2_class_b",   {28'b0, out_class_b}, 32'd0);
        chk("t2_count",     {29'b0, count}, 32'd1);
        drain("t2_drain");

        // Fill to full; the fifth request must be dropped.
        push(32'h3F800000, 32'hBF800000, 1'b1, 4'b0000, 4'b0000);
        push(32'h40000000, 32'hC0000000, 1'b0, 4'b0000, 4'b0000);
        push(32'h40400000, 32'h00000000, 1'b1, 4'b0000, 4'b0001);
        push(32'h7F800000, 32'h00800000, 1'b0, 4'b0100, 4'b0000);
        chk("t3_count_full", {29'b0, count},    32'd4);
        chk("t3_in_ready",   {31'b0, in_ready}, 32'd0);
        push(32'h41000000, 32'h41100000, 1'b0, 4'b0000, 4'b0000);
        chk("t3_count_drop", {29'b0, count},    32'd4);
        // Full with pop: the offered word is still refused this cycle.
        step(1'b1, 32'h42000000, 32'h42000000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("t3_ready_after_pop", {31'b0, in_ready}, 32'd1);
        chk("t3_count_after_pop", {29'b0, count},    32'd3);
        drain("t3_drain");

        // Classification: NaN / -inf, then -0 / smallest denorm.
        push(32'h7FC00000, 32'hFF800000, 1'b1, 4'b1000, 4'b0100);
        push(32'h80000000, 32'h00000001, 1'b0, 4'b0001, 4'b0010);
        chk("t4_class_a_nan",  {28'b0, out_class_a}, 32'h8);
        chk("t4_class_b_inf",  {28'b0, out_class_b}, 32'h4);
        chk("t4_out_op",       {31'b0, out_op},      32'd1);
        pop1();
        chk("t4_class_a_zero", {28'b0, out_class_a}, 32'h1);
        chk("t4_class_b_den",  {28'b0, out_class_b}, 32'h2);
        drain("t4_drain");

        // Push and pop in the same cycle at count 2, then flush with a push.
        push(32'h3F000000, 32'h3E800000, 1'b0, 4'b0000, 4'b0000);
        push(32'h3E000000, 32'h3D800000, 1'b1, 4'b0000, 4'b0000);
        step(1'b1, 32'h3D000000, 32'h3C800000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("t5_count_pushpop", {29'b0, count}, 32'd2);
        chk("t5_head_advanced", out_a, 32'h3E000000);
        step(1'b1, 32'h12345678, 32'h00000000, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        chk("t5_flush_count",     {29'b0, count},     32'd0);
        chk("t5_flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_flush_out_a",     out_a,              32'd0);
        push(32'h40A00000, 32'h40C00000, 1'b1, 4'b0000, 4'b0000);
        chk("t5_head_after_flush",  out_a,          32'h40A00000);
        chk("t5_count_after_flush", {29'b0, count}, 32'd1);
        drain("t5_drain");

        // Asynchronous reset in the middle of a cycle with entries queued.
        push(32'h3F800000, 32'h3F800000, 1'b0, 4'b0000, 4'b0000);
        push(32'h40000000, 32'h40000000, 1'b1, 4'b0000, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midreset_count",     {29'b0, count},     32'd0);
        chk("midreset_in_ready",  {31'b0, in_ready},  32'd1);
        chk("midreset_out_b",     out_b,              32'd0);
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef FP_ISSUE_STATS_EN
        chk("stat_issued_reset",     stat_issued,               32'd0);
        chk("stat_full_stall_reset", {16'b0, stat_full_stall}, 32'd0);
        push(32'h3F800000, 32'h40000000, 1'b0, 4'b0000, 4'b0000);
        push(32'h40400000, 32'h40800000, 1'b0, 4'b0000, 4'b0000);
        push(32'h40A00000, 32'h40C00000, 1'b0, 4'b0000, 4'b0000);
        push(32'h40E00000, 32'h41000000, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            push(32'h41100000, 32'h41200000, 1'b0, 4'b0000, 4'b0000);
        end
        drain("t6_drain_a");
        push(32'h41300000, 32'h41400000, 1'b1, 4'b0000, 4'b0000);
        push(32'h41500000, 32'h41600000, 1'b1, 4'b0000, 4'b0000);
        drain("t6_drain_b");
        step(1'b0, 32'h0, 32'h0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("stat_full_stall", {16'b0, stat_full_stall}, 32'd3);
        chk("stat_issued",     stat_issued,               32'd6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
